mux2_rr_arbiter: RTL and testbench
==================================

MUX2_RR_ARBITER -- requirements
Module: mux2_rr_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, data width of each requester and of the output.
REQ-002 Parameter MAX_BURST, default 4, maximum beats per grant before forced release; legal range 1..255.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req0_valid  input  1  requester 0 has a beat.
REQ-006 req0_data  input  DATA_W  requester 0 beat data.
REQ-007 req0_last  input  1  requester 0 beat ends its packet.
REQ-008 req0_ready  output  1  requester 0 beat accepted this cycle.
REQ-009 req1_valid, req1_data, req1_last, req1_ready  same as REQ-005..008, for requester 1.
REQ-010 out_valid  output  1  granted beat presented downstream.
REQ-011 out_data  output  DATA_W  granted requester's data.
REQ-012 out_last  output  1  granted requester's last flag.
REQ-013 out_ready  input  1  downstream accepts beat.
REQ-014 sel  output  1  mux select; 1 only while requester 1 is granted, else 0.
REQ-015 busy  output  1  a grant is active (state not IDLE).

Function
REQ-016 The FSM SHALL have states IDLE, G0, G1, with the state register, last_grant bit and beat counter as the only sequential elements.
REQ-017 In IDLE: out_valid=0, req0_ready=0, req1_ready=0, busy=0, sel=0.
REQ-018 In IDLE with exactly one reqN_valid=1, next state SHALL be GN.
REQ-019 In IDLE with both valid, next state SHALL be G(not last_grant), giving round-robin priority.
REQ-020 Grant latency SHALL be exactly one cycle: a valid seen in IDLE at cycle n yields out_valid at cycle n+1.
REQ-021 In GN: out_data/out_last/out_valid SHALL equal reqN_data/reqN_last/reqN_valid combinationally, reqN_ready = out_ready, and the other ready SHALL be 0.
REQ-022 A transfer SHALL occur when out_valid & out_ready; only transfers increment the beat counter.
REQ-023 On entry to GN, the counter SHALL clear to 0 and last_grant SHALL be set to N.
REQ-024 Release condition: a transfer with out_last=1, or a transfer that makes the counter equal MAX_BURST.
REQ-025 On release: next state SHALL be G(other) if the other requester's valid=1 that cycle, else IDLE; there is no bubble on a handover.
REQ-026 Without release, the grant SHALL be held even if reqN_valid drops to 0; out_valid then follows it to 0.
REQ-027 The counter width SHALL be clog2(MAX_BURST+1); it SHALL never exceed MAX_BURST.
REQ-028 With MAX_BURST=1, the block SHALL alternate per beat when both requesters are continuously valid.
REQ-029 Forced release mid-packet (out_last=0) SHALL NOT drop the beat; the packet resumes on that requester's next grant.

Reset
REQ-030 Assertion of rst_n=0 SHALL immediately force state=IDLE, counter=0 and last_grant=1, so requester 0 wins the first contention.
REQ-031 During reset, all outputs SHALL follow REQ-017, including reset asserted mid-burst.
REQ-032 The first arbitration SHALL occur on the first rising edge after rst_n deasserts.

Structure
REQ-033 Shared package mux_arb_pkg SHALL hold the state enum typedef (IDLE, G0, G1) and the default DATA_W/MAX_BURST constants.
REQ-034 The datapath SHALL be one sub-module, mux2_dp: a DATA_W+2-bit 2:1 mux (data, last, valid) driven by sel; the FSM is in the top module.

Verification
REQ-035 After reset, req0 and req1 are both valid with 1-beat packets and out_ready=1 -> grants go G0, G1, G0, ...; the first out_data equals req0_data at cycle 1.
REQ-036 MAX_BURST=4, req0 sends a 10-beat packet, req1 is idle -> 4 beats, then release to IDLE, then regrant G0; all 10 beats arrive in order with one-cycle gaps.
REQ-037 MAX_BURST=4, both send 6-beat packets -> order is 4 of req0, 4 of req1, 2 of req0, 2 of req1, with no idle cycle at handovers.
REQ-038 out_ready held 0 for 5 cycles mid-grant -> the counter is unchanged, sel is stable, and no ready pulses occur.
REQ-039 rst_n pulsed low during the G1 beat 2 -> outputs drop to 0 asynchronously; after release, a simultaneous request grants req0 first.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and default sizing for the two-requester round-robin arbiter.
package mux_arb_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BURST_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mux2_dp.sv
// Arbiter datapath: 2:1 mux of {valid, last, data}; valid is gated off while no grant is held.
module mux2_dp #(
  parameter int DATA_W = 8
) (
  input  logic              i_sel,
  input  logic              i_en,
  input  logic              i_valid0,
  input  logic              i_last0,
  input  logic [DATA_W-1:0] i_data0,
  input  logic              i_valid1,
  input  logic              i_last1,
  input  logic [DATA_W-1:0] i_data1,
  output logic              o_valid,
  output logic              o_last,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W+1:0] w_bus0;
  logic [DATA_W+1:0] w_bus1;
  logic [DATA_W+1:0] w_mux;

  assign w_bus0 = {i_valid0, i_last0, i_data0};
  assign w_bus1 = {i_valid1, i_last1, i_data1};
  assign w_mux  = i_sel ? w_bus1 : w_bus0;

  assign o_data  = w_mux[DATA_W-1:0];
  assign o_last  = w_mux[DATA_W];
  assign o_valid = i_en & w_mux[DATA_W+1];

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin packet arbiter with a per-grant beat limit.
// Outputs are decoded from the state register, so reset clears them without waiting for a clock.
module mux2_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sel,
  output logic              busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       r_state;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;

  logic             w_sel;
  logic             w_busy;
  logic             w_xfer;
  logic             w_release;
  logic             w_other_valid;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_sel         = (r_state == G1);
  assign w_busy        = (r_state != IDLE);
  assign w_xfer        = out_valid & out_ready;
  assign w_cnt_inc     = r_cnt + CNT_W'(1);
  assign w_release     = w_xfer & (out_last | (w_cnt_inc == CNT_W'(MAX_BURST)));
  assign w_other_valid = w_sel ? req0_valid : req1_valid;

  assign sel        = w_sel;
  assign busy       = w_busy;
  assign req0_ready = (r_state == G0) & out_ready;
  assign req1_ready = (r_state == G1) & out_ready;

  mux2_dp #(
    .DATA_W (DATA_W)
  ) u_dp (
    .i_sel    (w_sel),
    .i_en     (w_busy),
    .i_valid0 (req0_valid),
    .i_last0  (req0_last),
    .i_data0  (req0_data),
    .i_valid1 (req1_valid),
    .i_last1  (req1_last),
    .i_data1  (req1_data),
    .o_valid  (out_valid),
    .o_last   (out_last),
    .o_data   (out_data)
  );

  // last_grant resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req0_valid && (!req1_valid || r_last_grant)) begin
            r_state      <= G0;
            r_last_grant <= 1'b0;
            r_cnt        <= '0;
          end else if (req1_valid) begin
            r_state      <= G1;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
          end
        end
        G0, G1: begin
          if (w_release) begin
            r_cnt <= '0;
            // Hand straight over to a waiting peer; no idle bubble between grants.
            if (w_other_valid) begin
              r_state      <= w_sel ? G0 : G1;
              r_last_grant <= ~w_sel;
            end else begin
              r_state <= IDLE;
            end
          end else if (w_xfer) begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: directed scenarios plus a randomized run against a grant/budget model.
module tb_mux2_rr_arbiter;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic [7:0] req0_data, req1_data, out_data;
  logic       out_valid, out_last, out_ready, sel, busy;

  logic       b_req0_valid, b_req0_last, b_req0_ready;
  logic       b_req1_valid, b_req1_last, b_req1_ready;
  logic [7:0] b_req0_data, b_req1_data, b_out_data;
  logic       b_out_valid, b_out_last, b_out_ready, b_sel, b_busy;

  int n_checks = 0;
  int n_fail   = 0;

  int         src_len  [2];
  int         src_sent [2];
  int         src_plen [2];
  logic [7:0] src_base [2];
  bit         src_gate [2];
  bit         hs       [2];

  always #5 clk = ~clk;

  mux2_rr_arbiter #(.DATA_W(8), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .busy(busy)
  );

  mux2_rr_arbiter #(.DATA_W(8), .MAX_BURST(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_last(b_req0_last), .req0_ready(b_req0_ready),
    .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_last(b_req1_last), .req1_ready(b_req1_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last), .out_ready(b_out_ready),
    .sel(b_sel), .busy(b_busy)
  );

  task automatic apply_src();
    req0_valid = src_gate[0] && (src_sent[0] < src_len[0]);
    req0_data  = src_base[0] + 8'(src_sent[0]);
    req0_last  = ((src_sent[0] + 1) % src_plen[0]) == 0;
    req1_valid = src_gate[1] && (src_sent[1] < src_len[1]);
    req1_data  = src_base[1] + 8'(src_sent[1]);
    req1_last  = ((src_sent[1] + 1) % src_plen[1]) == 0;
  endtask

  task automatic set_src(input int n, input int len, input int plen, input logic [7:0] base);
    src_len[n]  = len;
    src_plen[n] = plen;
    src_base[n] = base;
    src_sent[n] = 0;
    src_gate[n] = 1'b1;
  endtask

  // One clock: advance sources on handshakes, drive new inputs after the edge, return at the falling edge.
  task automatic step(input logic ordy, input bit rnd_gate);
    hs[0] = req0_valid & req0_ready;
    hs[1] = req1_valid & req1_ready;
    if (hs[0]) $display("beat req0 data=%h last=%b", req0_data, req0_last);
    if (hs[1]) $display("beat req1 data=%h last=%b", req1_data, req1_last);
    @(posedge clk);
    #1;
    if (hs[0]) src_sent[0]++;
    if (hs[1]) src_sent[1]++;
    if (rnd_gate) begin
      src_gate[0] = ($urandom_range(0, 3) != 0);
      src_gate[1] = ($urandom_range(0, 3) != 0);
    end
    out_ready = ordy;
    apply_src();
    @(negedge clk);
  endtask

  task automatic b_idle();
    b_req0_valid = 0; b_req0_last = 0; b_req0_data = 0;
    b_req1_valid = 0; b_req1_last = 0; b_req1_data = 0;
    b_out_ready  = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    out_ready = 1'b0;
    for (int n = 0; n < 2; n++) set_src(n, 0, 1, 8'h00);
    apply_src();
    b_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_src(0, 4, 4, 8'h30);
    set_src(1, 4, 4, 8'h50);
    out_ready = 1'b1;
    apply_src();
    b_req0_valid = 1; b_req1_valid = 1; b_out_ready = 1;
    #1;
    n_checks++;
    if ({out_valid, req0_ready, req1_ready, sel, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b expected 00000", {out_valid, req0_ready, req1_ready, sel, busy});
    end
    n_checks++;
    if ({b_out_valid, b_req0_ready, b_req1_ready, b_sel, b_busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_idle_b: got %b expected 00000", {b_out_valid, b_req0_ready, b_req1_ready, b_sel, b_busy});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, req0_ready, req1_ready, sel, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_hold: got %b expected 00000", {out_valid, req0_ready, req1_ready, sel, busy});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b expected 00", {out_valid, busy});
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, sel, out_data} !== {1'b1, 1'b0, 8'h30}) begin
      n_fail++;
      $display("FAIL first_grant: got v=%b sel=%b d=%h expected v=1 sel=0 d=30", out_valid, sel, out_data);
    end
    b_idle();
  endtask

  task automatic test_rr_single();
    logic       exp_sel;
    logic [7:0] exp_data;
    do_reset();
    set_src(0, 100, 1, 8'h00);
    set_src(1, 100, 1, 8'h80);
    out_ready = 1'b1;
    apply_src();
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_latency: got out_valid=%b expected 0", out_valid);
    end
    for (int c = 1; c <= 8; c++) begin
      step(1'b1, 1'b0);
      exp_sel  = 1'((c - 1) % 2);
      exp_data = (exp_sel ? 8'h80 : 8'h00) + 8'((c - 1) / 2);
      n_checks++;
      if ({out_valid, sel, out_data, out_last} !== {1'b1, exp_sel, exp_data, 1'b1}) begin
        n_fail++;
        $display("FAIL rr_single c%0d: got v=%b sel=%b d=%h l=%b expected v=1 sel=%b d=%h l=1",
                 c, out_valid, sel, out_data, out_last, exp_sel, exp_data);
      end
    end
  endtask

  task automatic test_long_packet();
    bit pat [14] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0};
    int k = 0;
    do_reset();
    set_src(0, 10, 10, 8'h10);
    out_ready = 1'b1;
    apply_src();
    #1;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) step(1'b1, 1'b0);
      n_checks++;
      if (out_valid !== pat[c] ||
          (pat[c] && (out_data !== 8'(8'h10 + k) || out_last !== (k == 9)))) begin
        n_fail++;
        $display("FAIL long_packet c%0d: got v=%b d=%h l=%b expected v=%b d=%h l=%b",
                 c, out_valid, out_data, out_last, pat[c], 8'(8'h10 + k), (k == 9));
      end
      if (pat[c]) k++;
    end
    n_checks++;
    if (src_sent[0] !== 10 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL long_packet_done: got beats=%0d busy=%b expected beats=10 busy=0", src_sent[0], busy);
    end
  endtask

  task automatic test_two_packets();
    logic [7:0] exp_d [12] = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h40, 8'h41, 8'h42, 8'h43,
                               8'h24, 8'h25, 8'h44, 8'h45};
    bit         exp_s [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    do_reset();
    set_src(0, 6, 6, 8'h20);
    set_src(1, 6, 6, 8'h40);
    out_ready = 1'b1;
    apply_src();
    #1;
    for (int c = 1; c <= 13; c++) begin
      step(1'b1, 1'b0);
      n_checks++;
      if (c == 13) begin
        if ({out_valid, busy} !== 2'b00) begin
          n_fail++;
          $display("FAIL two_packets_end: got v=%b busy=%b expected 0 0", out_valid, busy);
        end
      end else if ({out_valid, sel, out_data, out_last} !==
                   {1'b1, exp_s[c-1], exp_d[c-1], exp_d[c-1][3:0] == 4'h5}) begin
        n_fail++;
        $display("FAIL two_packets c%0d: got v=%b sel=%b d=%h l=%b expected v=1 sel=%b d=%h",
                 c, out_valid, sel, out_data, out_last, exp_s[c-1], exp_d[c-1]);
      end
    end
  endtask

  task automatic test_stall();
    logic       exp_sel;
    logic [7:0] exp_data;
    do_reset();
    set_src(0, 10, 10, 8'h10);
    set_src(1, 3, 3, 8'h60);
    out_ready = 1'b1;
    apply_src();
    #1;
    for (int c = 1; c <= 10; c++) begin
      step(!(c >= 3 && c <= 7), 1'b0);
      n_checks++;
      if (c >= 3 && c <= 7) begin
        if ({out_valid, sel, busy, req0_ready, req1_ready, out_data} !== {5'b10100, 8'h12}) begin
          n_fail++;
          $display("FAIL stall c%0d: got v=%b sel=%b busy=%b r0=%b r1=%b d=%h expected 1 0 1 0 0 12",
                   c, out_valid, sel, busy, req0_ready, req1_ready, out_data);
        end
      end else begin
        exp_sel  = (c == 10);
        exp_data = (c == 10) ? 8'h60 : 8'h10 + 8'((c <= 2) ? c - 1 : c - 6);
        if ({out_valid, sel, out_data, req0_ready | req1_ready} !== {1'b1, exp_sel, exp_data, 1'b1}) begin
          n_fail++;
          $display("FAIL stall_resume c%0d: got v=%b sel=%b d=%h expected v=1 sel=%b d=%h",
                   c, out_valid, sel, out_data, exp_sel, exp_data);
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_src(0, 6, 6, 8'h20);
    set_src(1, 6, 6, 8'h40);
    out_ready = 1'b1;
    apply_src();
    #1;
    for (int c = 1; c <= 7; c++) step(1'b1, 1'b0);
    n_checks++;
    if ({sel, out_valid, out_data} !== {2'b11, 8'h42}) begin
      n_fail++;
      $display("FAIL mid_burst_pre: got sel=%b v=%b d=%h expected sel=1 v=1 d=42", sel, out_valid, out_data);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, req0_ready, req1_ready, sel, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_burst_async: got %b expected 00000", {out_valid, req0_ready, req1_ready, sel, busy});
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0);
    n_checks++;
    if ({out_valid, sel, out_data} !== {2'b10, 8'h24}) begin
      n_fail++;
      $display("FAIL mid_burst_regrant: got v=%b sel=%b d=%h expected v=1 sel=0 d=24", out_valid, sel, out_data);
    end
  endtask

  task automatic test_alternate();
    logic       exp_sel;
    logic [7:0] exp_data;
    do_reset();
    b_req0_valid = 1; b_req1_valid = 1; b_out_ready = 1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      b_req0_data = 8'($urandom);
      b_req1_data = 8'($urandom);
      @(negedge clk);
      exp_sel  = 1'((c - 1) % 2);
      exp_data = exp_sel ? b_req1_data : b_req0_data;
      n_checks++;
      if ({b_out_valid, b_sel, b_out_data, b_out_last, b_busy, b_req0_ready, b_req1_ready} !==
          {1'b1, exp_sel, exp_data, 1'b0, 1'b1, ~exp_sel, exp_sel}) begin
        n_fail++;
        $display("FAIL alternate c%0d: got v=%b sel=%b d=%h r0=%b r1=%b expected v=1 sel=%b d=%h",
                 c, b_out_valid, b_sel, b_out_data, b_req0_ready, b_req1_ready, exp_sel, exp_data);
      end
    end
    b_idle();
  endtask

  // Model: owner of the grant (-1 = none), remaining beat budget, and who was granted last.
  task automatic test_random();
    int          owner = -1;
    int          last_owner = 1;
    int          budget = 0;
    bit          v [2];
    bit          l [2];
    logic [13:0] exp_vec, act_vec;
    do_reset();
    set_src(0, 100000, $urandom_range(1, 7), 8'h00);
    set_src(1, 100000, $urandom_range(1, 7), 8'h80);
    src_gate[0] = ($urandom_range(0, 3) != 0);
    src_gate[1] = ($urandom_range(0, 3) != 0);
    out_ready = ($urandom_range(0, 3) != 0);
    apply_src();
    #1;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) step($urandom_range(0, 3) != 0, 1'b1);
      if (owner == 0)
        exp_vec = {req0_valid, req0_last, req0_data, 1'b0, 1'b1, out_ready, 1'b0};
      else if (owner == 1)
        exp_vec = {req1_valid, req1_last, req1_data, 1'b1, 1'b1, 1'b0, out_ready};
      else
        exp_vec = '0;
      act_vec = {out_valid, (owner < 0) ? 9'h000 : {out_last, out_data}, sel, busy, req0_ready, req1_ready};
      n_checks++;
      if (act_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL random c%0d: got {v,l,d,sel,busy,r0,r1}=%h expected %h (owner %0d)",
                 c, act_vec, exp_vec, owner);
      end
      v[0] = req0_valid; v[1] = req1_valid;
      l[0] = req0_last;  l[1] = req1_last;
      if (owner < 0) begin
        if (v[0] || v[1]) begin
          owner      = (v[0] && v[1]) ? 1 - last_owner : (v[0] ? 0 : 1);
          last_owner = owner;
          budget     = MB;
        end
      end else if (v[owner] && out_ready) begin
        budget--;
        if (l[owner] || budget == 0) begin
          if (v[1 - owner]) begin
            owner      = 1 - owner;
            last_owner = owner;
            budget     = MB;
          end else begin
            owner = -1;
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rr_single();
    test_long_packet();
    test_two_packets();
    test_stall();
    test_reset_mid_burst();
    test_alternate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
